// File: rtl/dma_stream_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_stream_loader_if
// Description : AXI4-Stream input and memory write port of the stream loader.
// Revision    : 1.0
// ============================================================================
interface dma_stream_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              s_axis_tready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;

    // Loader side: stream sink, memory write initiator.
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, mem_ready,
        output s_axis_tready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, mem_ready,
        input  s_axis_tready, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/dma_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : dma_stream_loader
// Description : Writes a DMA MM2S word stream to consecutive memory addresses
//               and checks the beat count against the programmed byte length.
// Revision    : 1.0
// ============================================================================
module dma_stream_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       byte_length,
    dma_stream_loader_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    output logic [ADDR_W:0]   words_written
);
    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RECV    = 3'd1;
    localparam logic [2:0] c_DISCARD = 3'd2;
    localparam logic [2:0] c_FLUSH   = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_exp_words;
    logic [31:0]       r_beat_cnt;
    logic [ADDR_W-1:0] r_wr_idx;
    logic [ADDR_W:0]   r_words;
    logic              r_err;
    logic [DATA_W-1:0] r_buf [0:1];
    logic              r_head;
    logic [1:0]        r_cnt;

    logic [31:0]       w_exp_words;
    logic [31:0]       w_beat_next;
    logic              w_tready;
    logic              w_accept;
    logic              w_push;
    logic              w_we;
    logic              w_pop;
    logic              w_tail;
    logic              w_set_err;
    logic              w_start_ok;

    // Ceiling division by 4 without a 33-bit intermediate.
    assign w_exp_words = {2'b00, byte_length[31:2]} + {31'd0, |byte_length[1:0]};
    assign w_beat_next = r_beat_cnt + 32'd1;
    assign w_start_ok  = (r_state == c_IDLE) && start;

    assign w_tready = ((r_state == c_RECV) && (r_cnt != 2'd2)) || (r_state == c_DISCARD);
    assign w_accept = bus.s_axis_tvalid && w_tready;
    assign w_push   = w_accept && (r_state == c_RECV);
    assign w_we     = (r_cnt != 2'd0);
    assign w_pop    = w_we && bus.mem_ready;
    assign w_tail   = r_head ^ r_cnt[0];

    assign w_set_err = (w_accept && (r_state == c_DISCARD)) ||
                       (w_accept && (r_state == c_RECV) && bus.s_axis_tlast &&
                        (w_beat_next < r_exp_words));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_exp_words == 32'd0) ? c_DONE : c_RECV;
                end
            end
            c_RECV: begin
                if (w_accept) begin
                    if (bus.s_axis_tlast) begin
                        w_state_nxt = c_FLUSH;
                    end else if (w_beat_next == r_exp_words) begin
                        w_state_nxt = c_DISCARD;
                    end
                end
            end
            c_DISCARD: begin
                if (w_accept && bus.s_axis_tlast) begin
                    w_state_nxt = c_FLUSH;
                end
            end
            c_FLUSH: begin
                if (r_cnt == 2'd0) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_base      <= '0;
            r_exp_words <= '0;
            r_beat_cnt  <= '0;
            r_wr_idx    <= '0;
            r_words     <= '0;
            r_err       <= 1'b0;
            r_head      <= 1'b0;
            r_cnt       <= 2'd0;
        end else begin
            r_state <= w_state_nxt;

            if (w_start_ok) begin
                r_base      <= base_addr;
                r_exp_words <= w_exp_words;
                r_beat_cnt  <= '0;
                r_wr_idx    <= '0;
                r_words     <= '0;
                r_err       <= 1'b0;
            end

            if (w_accept) begin
                r_beat_cnt <= w_beat_next;
            end

            if (w_set_err) begin
                r_err <= 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase

            if (w_pop) begin
                r_head   <= ~r_head;
                r_wr_idx <= r_wr_idx + 1'b1;
                if (r_words != '1) begin
                    r_words <= r_words + 1'b1;
                end
            end
        end
    end

    // Entry storage needs no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[w_tail] <= bus.s_axis_tdata;
        end
    end

    assign bus.s_axis_tready = w_tready;
    assign bus.mem_we        = w_we;
    assign bus.mem_addr      = w_we ? (r_base + r_wr_idx) : '0;
    assign bus.mem_wdata     = w_we ? r_buf[r_head] : '0;

    assign busy          = (r_state == c_RECV) || (r_state == c_DISCARD) || (r_state == c_FLUSH);
    assign done          = (r_state == c_DONE);
    assign err_len       = r_err;
    assign words_written = r_words;
endmodule
`default_nettype wire

// File: tb/tb_dma_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_stream_loader
// Description : Self-checking bench: vector table, random transfers, corners.
// Revision    : 1.0
// ============================================================================
module tb_dma_stream_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [31:0] byte_length;
    logic        busy;
    logic        done;
    logic        err_len;
    logic [10:0] words_written;

    int checks = 0;
    int errors = 0;

    dma_stream_loader_if #(.DATA_W(32), .ADDR_W(10)) bus ();

    dma_stream_loader #(.DATA_W(32), .ADDR_W(10)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .byte_length   (byte_length),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .err_len       (err_len),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  base;
        logic [31:0] blen;
        int          tlast_pos;
        int          mode;
        bit          poke;
        int          exp_writes;
        bit          exp_err;
        int          exp_words;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp_v);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return {6'd0, bus.s_axis_tready, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                busy, done, err_len, words_written};
    endfunction

    // Transfer-level outcome: words kept = min(beats up to tlast, ceil(bytes/4)).
    function automatic void ref_model(input logic [31:0] blen, input int tlast_pos,
                                      output int writes, output bit err);
        longint ew;
        ew = (longint'(blen) + 3) / 4;
        if (ew == 0) begin
            writes = 0;
            err    = 1'b0;
        end else begin
            writes = (tlast_pos < ew) ? tlast_pos : int'(ew);
            err    = (tlast_pos != ew);
        end
    endfunction

    task automatic run_transfer(input logic [9:0] base, input logic [31:0] blen,
                                input int tlast_pos, input int mode, input int vprob,
                                input bit poke, input bit rand_data,
                                input int exp_writes, input bit exp_err,
                                input int exp_words, input string name);
        logic [31:0] dq[$];
        logic [9:0]  ea[$];
        logic [31:0] ed[$];
        int          beat = 0;
        int          cyc = 0;
        bit          done_seen = 1'b0;
        bit          stall = 1'b0;
        bit          busy_ok = 1'b1;
        bit          acc;
        logic [9:0]  pa = '0;
        logic [31:0] pd = '0;
        logic        err_at_done = 1'b0;
        logic [10:0] words_at_done = '0;
        logic        busy_at_done = 1'b1;

        for (int i = 0; i < tlast_pos; i++) begin
            dq.push_back(rand_data ? $urandom : (32'hA0 + 32'(i)));
        end
        for (int i = 0; i < exp_writes; i++) begin
            ea.push_back(10'(base + 10'(i)));
            ed.push_back(dq[i]);
        end

        @(posedge clk); #1;
        start       = 1'b1;
        base_addr   = base;
        byte_length = blen;
        while (!done_seen && cyc < 2000) begin
            if (cyc == 1) start = 1'b0;
            // A start issued mid-transfer must not disturb the latched setup.
            if (poke && cyc == 2) begin
                start       = 1'b1;
                base_addr   = base ^ 10'h155;
                byte_length = 32'd400;
            end
            if (poke && cyc == 3) start = 1'b0;
            if (!bus.s_axis_tvalid && beat < tlast_pos && $urandom_range(1, 100) <= vprob) begin
                bus.s_axis_tvalid = 1'b1;
                bus.s_axis_tdata  = dq[beat];
                bus.s_axis_tlast  = (beat == tlast_pos - 1);
            end
            case (mode)
                0:       bus.mem_ready = 1'b1;
                1:       bus.mem_ready = (cyc % 3 == 0);
                default: bus.mem_ready = 1'($urandom_range(0, 1));
            endcase

            @(negedge clk);
            if (stall) begin
                chk({name, "_stall_hold"}, {21'd0, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                    {21'd0, 1'b1, pa, pd});
            end
            if (bus.mem_we && bus.mem_ready) begin
                if (ea.size() == 0) begin
                    chk({name, "_extra_write"}, 64'd1, 64'd0);
                end else begin
                    chk({name, "_write"}, {22'd0, bus.mem_addr, bus.mem_wdata},
                        {22'd0, ea.pop_front(), ed.pop_front()});
                end
            end
            stall = bus.mem_we && !bus.mem_ready;
            pa    = bus.mem_addr;
            pd    = bus.mem_wdata;
            if (cyc >= 1 && !done && !busy) busy_ok = 1'b0;
            acc = bus.s_axis_tvalid && bus.s_axis_tready;
            if (done) begin
                done_seen     = 1'b1;
                err_at_done   = err_len;
                words_at_done = words_written;
                busy_at_done  = busy;
            end

            @(posedge clk); #1;
            if (acc) begin
                beat++;
                bus.s_axis_tvalid = 1'b0;
                bus.s_axis_tlast  = 1'b0;
            end
            cyc++;
        end

        chk({name, "_done_seen"}, 64'(done_seen), 64'd1);
        chk({name, "_writes_left"}, 64'(ea.size()), 64'd0);
        chk({name, "_beats_taken"}, 64'(beat), 64'(tlast_pos));
        chk({name, "_err_len"}, 64'(err_at_done), 64'(exp_err));
        chk({name, "_words_written"}, 64'(words_at_done), 64'(exp_words));
        chk({name, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
        chk({name, "_busy_during"}, 64'(busy_ok), 64'd1);
        @(negedge clk);
        chk({name, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        int          wr;
        bit          er;
        int          ew;
        int          tp;
        logic [31:0] bl;
        bit          late_done;

        vecs[0] = '{10'h010, 32'd16, 4, 0, 1'b0, 4, 1'b0, 4};
        vecs[1] = '{10'h010, 32'd16, 4, 1, 1'b1, 4, 1'b0, 4};
        vecs[2] = '{10'h010, 32'd16, 2, 2, 1'b0, 2, 1'b1, 2};
        vecs[3] = '{10'h010, 32'd8,  4, 0, 1'b0, 2, 1'b1, 2};
        vecs[4] = '{10'h020, 32'd5,  2, 0, 1'b0, 2, 1'b0, 2};
        vecs[5] = '{10'h3FF, 32'd12, 3, 1, 1'b0, 3, 1'b0, 3};
        vecs[6] = '{10'h100, 32'd0,  0, 0, 1'b0, 0, 1'b0, 0};
        vecs[7] = '{10'h200, 32'd7,  1, 2, 1'b0, 1, 1'b1, 1};

        rst_n             = 1'b0;
        start             = 1'b0;
        base_addr         = '0;
        byte_length       = '0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tlast  = 1'b0;
        bus.mem_ready     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", all_outputs(), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_tready", 64'(bus.s_axis_tready), 64'd0);
        bus.s_axis_tvalid = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_transfer(vecs[i].base, vecs[i].blen, vecs[i].tlast_pos, vecs[i].mode, 100,
                         vecs[i].poke, 1'b0, vecs[i].exp_writes, vecs[i].exp_err,
                         vecs[i].exp_words, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            ew = $urandom_range(0, 8);
            bl = (ew == 0) ? 32'd0 : 32'(4 * ew - $urandom_range(0, 3));
            tp = (ew == 0) ? 0 : $urandom_range(1, ew + 3);
            ref_model(bl, tp, wr, er);
            run_transfer(10'($urandom), bl, tp, 2, $urandom_range(40, 100), 1'b0, 1'b1,
                         wr, er, wr, $sformatf("rnd%0d", i));
        end

        // Zero-length: straight to DONE after the start edge.
        @(posedge clk); #1;
        start       = 1'b1;
        base_addr   = 10'h123;
        byte_length = 32'd0;
        @(negedge clk);
        chk("zero_before", {61'd0, busy, done, bus.mem_we}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_done", {60'd0, busy, done, bus.mem_we, err_len}, 64'h4);
        @(negedge clk);
        chk("zero_after", {62'd0, busy, done}, 64'd0);

        // Reset in the middle of a wrapping transfer.
        @(posedge clk); #1;
        start       = 1'b1;
        base_addr   = 10'h3FF;
        byte_length = 32'd12;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        start             = 1'b0;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 32'h11;
        bus.s_axis_tlast  = 1'b0;
        @(posedge clk); #1;
        bus.s_axis_tdata = 32'h22;
        @(negedge clk);
        chk("rst_seq_first", {21'd0, bus.mem_we, bus.mem_addr, bus.mem_wdata},
            {21'd0, 1'b1, 10'h3FF, 32'h11});
        @(posedge clk); #1;
        rst_n             = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("rst_seq_wrap", {21'd0, bus.mem_we, bus.mem_addr, bus.mem_wdata},
            {21'd0, 1'b1, 10'h000, 32'h22});
        @(negedge clk);
        chk("rst_mid_outputs", all_outputs(), 64'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        late_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) late_done = 1'b1;
        end
        chk("rst_no_done", 64'(late_done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dma_stream_loader.md
Name: dma_stream_loader

Overview:
- AXI4-Stream slave that consumes the DMA MM2S data stream. The DMA is started by the AXI-Lite DMA control block, which writes the source address and byte length.
- Writes each received 32-bit word into the core's instruction/data memory through a simple write port with backpressure. Words go to consecutive word addresses from a programmed base.
- Checks the received word count against the programmed byte length, then reports done, error and words written back to the sequencer that issued the DMA start.

Parameters:
- DATA_W, 32, stream and memory data width in bits (fixed at 32; byte length is converted to words as bytes/4).
- ADDR_W, 10, memory word-address width; addresses wrap modulo 2^ADDR_W.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  arm the loader; sampled only in IDLE
- base_addr  input  ADDR_W  first memory word address, latched on start
- byte_length  input  32  expected transfer size in bytes, latched on start (same value given to DMA control)
- s_axis_tdata  input  DATA_W  stream data
- s_axis_tvalid  input  1  stream valid
- s_axis_tlast  input  1  last beat of stream
- s_axis_tready  output  1  stream ready
- mem_we  output  1  memory write request
- mem_addr  output  ADDR_W  memory word address
- mem_wdata  output  DATA_W  memory write data
- mem_ready  input  1  memory accepts the write this cycle
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle completion pulse
- err_len  output  1  sticky length mismatch, cleared on next accepted start
- words_written  output  ADDR_W+1  memory writes completed in the current or last transfer

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, 2-entry buffer emptied, write index 0.
  - Outputs: s_axis_tready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err_len=0, words_written=0.
  - Reset mid-transfer aborts immediately. No done pulse. Any beats still in flight are dropped.
- expected_words = (byte_length+3)>>2, computed on start and held in a 32-bit register.
- States:
  - IDLE:
    - start=1 latches base_addr and expected_words, clears err_len, words_written and the beat counter, and sets busy=1.
    - If expected_words==0 the next state is DONE; otherwise RECV.
  - RECV:
    - s_axis_tready = buffer not full (fewer than 2 entries). A beat is accepted when tvalid&&tready and pushed into the buffer.
    - Beat counter increments per accepted beat.
    - tlast on beat N (1-based) with N<expected_words: set err_len and go to FLUSH.
    - tlast with N==expected_words: go to FLUSH, no error.
    - N reaches expected_words without tlast: go to DISCARD.
  - DISCARD:
    - s_axis_tready=1; beats are accepted and not buffered.
    - Set err_len on the first discarded beat. On the tlast beat go to FLUSH.
  - FLUSH:
    - s_axis_tready=0. When the buffer is empty and no write is pending, go to DONE.
  - DONE:
    - done=1 and busy=0 for this cycle only; next state IDLE.
- Memory side:
  - mem_we=1 whenever the buffer is non-empty. mem_wdata is the head entry; mem_addr = base + write index (mod 2^ADDR_W).
  - When mem_we&&mem_ready, pop the buffer and increment the write index and words_written.
  - mem_addr and mem_wdata stay stable while mem_we=1 and mem_ready=0.
- Latency: a beat accepted at edge T is presented on the memory port in the following cycle, at the earliest.
- Push and pop in the same cycle keep the occupancy unchanged. With mem_ready held at 1 the stream sustains 1 beat/cycle.
- start while busy is ignored. start is honoured in IDLE only; in the DONE cycle it is not sampled.
- tvalid during IDLE is not accepted (tready=0).
- Write-address wrap past 2^ADDR_W-1 wraps to 0 silently. words_written saturates at its maximum value.

Test Plan:
- byte_length=16, base=0x010, 4 beats 0xA0..0xA3 with tlast on beat 4, mem_ready=1 -> writes 0x010..0x013 with those values, done pulse, err_len=0, words_written=4.
- Same transfer with mem_ready toggling 1,0,0,1... -> tready drops while the buffer holds 2 entries, no beat lost or duplicated, mem_addr/mem_wdata stable during stalls, 4 writes in order.
- byte_length=16, tlast on beat 2 -> 2 writes, err_len=1, done pulse, returns to IDLE.
- byte_length=8, 4 beats with tlast on beat 4 -> 2 writes, beats 3 and 4 accepted and discarded, err_len=1, done.
- byte_length=0 -> done 2 cycles after start, no mem_we, err_len=0. byte_length=5 -> expected 2 words.
- base=0x3FF, 3 beats -> addresses 0x3FF, 0x000, 0x001. Assert rst_n=0 after the second beat -> all outputs return to reset values next edge, no done pulse.
